// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared types and constants for the Viterbi link frame sequencer:
//   - frame_state_t : frame sequencer states
//   - ERR_CT_W      : width of the per-frame error / injection counters
//   - MASK_CLEAN / MASK_BOTH : channel XOR mask values for one 2-bit symbol
//   - sat_add       : saturating add used by both counters
// -----------------------------------------------------------------------------
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } frame_state_t;

    localparam int ERR_CT_W = 16;

    localparam logic [1:0] MASK_CLEAN = 2'b00;
    localparam logic [1:0] MASK_BOTH  = 2'b11;

    // Sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CT_W-1:0] sat_add(
        input logic [ERR_CT_W-1:0] a,
        input logic [ERR_CT_W-1:0] b
    );
        logic [ERR_CT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ERR_CT_W] ? {ERR_CT_W{1'b1}} : sum[ERR_CT_W-1:0];
    endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl_if
// Payload bit stream handshake into the frame sequencer.
//   din_valid_i : source has a payload bit
//   din_i       : payload bit
//   din_ready_o : sequencer accepts the bit this cycle
// master = payload source, slave = frame sequencer.
// -----------------------------------------------------------------------------
interface viterbi_frame_ctrl_if;
    logic din_valid_i;
    logic din_i;
    logic din_ready_o;

    modport master (
        output din_valid_i,
        output din_i,
        input  din_ready_o
    );

    modport slave (
        input  din_valid_i,
        input  din_i,
        output din_ready_o
    );
endinterface

// File: rtl/viterbi_ref_delay.sv
// -----------------------------------------------------------------------------
// viterbi_ref_delay
// Fixed-depth shift register, one stage per clock, cleared by reset.
// Used for the channel mask alignment line and the payload reference line.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   din  : value entering the line this cycle
//   dout : value that entered DEPTH clocks ago (din itself when DEPTH is 0)
// -----------------------------------------------------------------------------
module viterbi_ref_delay #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_line
            logic [WIDTH-1:0] stage_reg [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl
// Frame sequencer for the encoder -> channel -> Viterbi decoder link.
// Accepts FRAME_LEN payload bits, appends TAIL_LEN zero flush bits, waits for
// the link pipeline to drain, then pulses done_o. Generates the channel error
// mask and counts injected channel bits and wrong decoded payload bits.
//
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start_i       : frame start request (accepted only when idle)
//   err_period_i  : injection period in symbols, 0 = no injection
//   err_burst_i   : corrupted symbols at the start of each period
//   din_if        : payload valid/ready stream (slave side)
//   enc_en_o      : encoder enable
//   enc_d_o       : encoder data
//   err_mask_o    : channel XOR mask, aligned with the encoder output symbol
//   dec_d_i       : decoder output bit
//   busy_o        : frame in progress
//   done_o        : one-cycle end-of-frame pulse
//   bit_err_ct_o  : wrong decoded payload bits, current/last frame
//   inj_ct_o      : corrupted channel bits, current/last frame
// -----------------------------------------------------------------------------
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 8,
    parameter int ENC_LAT   = 1,
    parameter int DEC_LAT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [7:0]           err_period_i,
    input  logic [3:0]           err_burst_i,
    viterbi_frame_ctrl_if.slave  din_if,
    output logic                 enc_en_o,
    output logic                 enc_d_o,
    output logic [1:0]           err_mask_o,
    input  logic                 dec_d_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ERR_CT_W-1:0]  bit_err_ct_o,
    output logic [ERR_CT_W-1:0]  inj_ct_o
);

    // Payload bit from cycle t meets its decoded copy at t + REF_DEPTH.
    localparam int REF_DEPTH = ENC_LAT + DEC_LAT;

    localparam int MAX_STEP = (FRAME_LEN > TAIL_LEN)
                            ? ((FRAME_LEN > REF_DEPTH) ? FRAME_LEN : REF_DEPTH)
                            : ((TAIL_LEN  > REF_DEPTH) ? TAIL_LEN  : REF_DEPTH);
    localparam int CNT_W    = (MAX_STEP > 1) ? $clog2(MAX_STEP) : 1;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(REF_DEPTH - 1);

    frame_state_t       state_reg;
    logic [CNT_W-1:0]   step_reg;
    logic               ready_reg;
    logic               flush_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [7:0]         period_reg;
    logic [3:0]         burst_reg;
    logic [7:0]         phase_reg;
    logic [ERR_CT_W-1:0] bit_err_reg;
    logic [ERR_CT_W-1:0] inj_reg;

    logic               xfer;
    logic               start_ok;
    logic               corrupt;
    logic [1:0]         mask_next;
    logic [1:0]         ref_out;

    // The encoder enable must coincide with the handshake, so it is decoded
    // from the registered ready/flush flags rather than registered itself.
    assign xfer     = ready_reg & din_if.din_valid_i;
    assign start_ok = (state_reg == IDLE) & start_i;
    assign enc_en_o = xfer | flush_reg;
    assign enc_d_o  = xfer & din_if.din_i;

    assign din_if.din_ready_o = ready_reg;
    assign busy_o             = busy_reg;
    assign done_o             = done_reg;
    assign bit_err_ct_o       = bit_err_reg;
    assign inj_ct_o           = inj_reg;

    // phase_reg is the symbol index modulo the period; the burst occupies the
    // first err_burst_i positions, so burst >= period corrupts every symbol.
    assign corrupt   = enc_en_o & (period_reg != 8'd0) & (phase_reg < {4'd0, burst_reg});
    assign mask_next = corrupt ? MASK_BOTH : MASK_CLEAN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            step_reg   <= '0;
            ready_reg  <= 1'b0;
            flush_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            period_reg <= 8'd0;
            burst_reg  <= 4'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        period_reg <= err_period_i;
                        burst_reg  <= err_burst_i;
                        step_reg   <= '0;
                        ready_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        state_reg  <= FEED;
                    end
                end
                FEED: begin
                    if (xfer) begin
                        if (step_reg == FEED_LAST) begin
                            step_reg  <= '0;
                            ready_reg <= 1'b0;
                            flush_reg <= 1'b1;
                            state_reg <= FLUSH;
                        end else begin
                            step_reg <= step_reg + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (step_reg == FLUSH_LAST) begin
                        step_reg  <= '0;
                        flush_reg <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        step_reg <= step_reg + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (step_reg == DRAIN_LAST) begin
                        step_reg  <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        step_reg <= step_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Injection phase and per-frame counters; cleared on an accepted start and
    // otherwise held once the frame has drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg   <= 8'd0;
            inj_reg     <= '0;
            bit_err_reg <= '0;
        end else if (start_ok) begin
            phase_reg   <= 8'd0;
            inj_reg     <= '0;
            bit_err_reg <= '0;
        end else begin
            if (enc_en_o) begin
                phase_reg <= (phase_reg == period_reg - 8'd1) ? 8'd0 : phase_reg + 8'd1;
            end
            if (corrupt) begin
                inj_reg <= sat_add(inj_reg, ERR_CT_W'(2));
            end
            if (ref_out[1] && (dec_d_i != ref_out[0])) begin
                bit_err_reg <= sat_add(bit_err_reg, ERR_CT_W'(1));
            end
        end
    end

    viterbi_ref_delay #(
        .WIDTH (2),
        .DEPTH (ENC_LAT)
    ) u_mask_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (mask_next),
        .dout (err_mask_o)
    );

    // Entry is {is_payload, bit}; tail and idle cycles enter as non-payload.
    viterbi_ref_delay #(
        .WIDTH (2),
        .DEPTH (REF_DEPTH)
    ) u_ref_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({xfer, din_if.din_i}),
        .dout (ref_out)
    );

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viterbi_frame_ctrl
// Randomized frames against a timeline model built from the frame rules:
// expected handshake/encoder/mask/busy/done per cycle, and expected counts.
// The decoder is modelled as an ideal fixed-latency echo of the encoder input
// with selectable bit flips.
// -----------------------------------------------------------------------------
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int FRAME_LEN = 64;
    localparam int TAIL_LEN  = 8;
    localparam int ENC_LAT   = 1;
    localparam int DEC_LAT   = 32;
    localparam int D         = ENC_LAT + DEC_LAT;
    localparam int MAXC      = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  err_period_i = 8'd0;
    logic [3:0]  err_burst_i = 4'd0;
    logic        dec_d_i = 1'b0;
    logic        enc_en_o, enc_d_o, busy_o, done_o;
    logic [1:0]  err_mask_o;
    logic [15:0] bit_err_ct_o, inj_ct_o;

    viterbi_frame_ctrl_if din_if();

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .ENC_LAT   (ENC_LAT),
        .DEC_LAT   (DEC_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .err_period_i (err_period_i),
        .err_burst_i  (err_burst_i),
        .din_if       (din_if),
        .enc_en_o     (enc_en_o),
        .enc_d_o      (enc_d_o),
        .err_mask_o   (err_mask_o),
        .dec_d_i      (dec_d_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bit_err_ct_o (bit_err_ct_o),
        .inj_ct_o     (inj_ct_o)
    );

    int   n_checks = 0;
    int   n_errs   = 0;
    int   frame_no = 0;
    int   last_bits = 0;
    int   last_inj  = 0;
    logic pay      [FRAME_LEN];
    bit   flip_pay [FRAME_LEN];
    bit   valid_at [MAXC];
    bit   flip_nonpay, start_busy_rand, start_at_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0: always valid, 1: three stall cycles mid-frame, 2: random stalls
    task automatic gen_valid(input int mode);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       valid_at[c] = 1'b1;
                1:       valid_at[c] = !(c >= 30 && c <= 32);
                default: valid_at[c] = (c >= 300) || ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic rand_pay();
        for (int k = 0; k < FRAME_LEN; k++) pay[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_flips();
        for (int k = 0; k < FRAME_LEN; k++) flip_pay[k] = 1'b0;
        flip_nonpay = 1'b0;
    endtask

    task automatic drive_idle();
        start_i            = 1'b0;
        din_if.din_valid_i = 1'($urandom_range(0, 1));
        din_if.din_i       = 1'($urandom_range(0, 1));
        dec_d_i            = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_checks(input string tag);
        check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_val({tag, "_done"}, 32'(done_o), 32'd0);
        check_val({tag, "_en"}, 32'(enc_en_o), 32'd0);
        check_val({tag, "_rdy"}, 32'(din_if.din_ready_o), 32'd0);
    endtask

    task automatic reset_abort();
        rst = 1'b0;
        #1;
        check_val("rst_rdy", 32'(din_if.din_ready_o), 32'd0);
        check_val("rst_en", 32'(enc_en_o), 32'd0);
        check_val("rst_d", 32'(enc_d_o), 32'd0);
        check_val("rst_mask", 32'(err_mask_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_bits", 32'(bit_err_ct_o), 32'd0);
        check_val("rst_inj", 32'(inj_ct_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        rst = 1'b1;
        last_bits = 0;
        last_inj  = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 drive_idle();
            @(negedge clk);
            idle_checks("post_rst");
        end
    endtask

    task automatic run_frame(input int period, input int burst, input int gap, input int abort_at);
        bit         e_en   [MAXC];
        bit         e_d    [MAXC];
        bit         e_rdy  [MAXC];
        bit         dflip  [MAXC];
        logic [1:0] e_mask [MAXC];
        int i, xfers, done_idx, e_bits, e_inj, sym, obs_done;

        for (int c = 0; c < MAXC; c++) begin
            e_en[c] = 1'b0; e_d[c] = 1'b0; e_rdy[c] = 1'b0; dflip[c] = 1'b0;
            e_mask[c] = MASK_CLEAN;
        end
        e_bits = 0; e_inj = 0; obs_done = -1;

        // Timeline relative to the start cycle (index 0).
        i = 1; xfers = 0;
        while (xfers < FRAME_LEN) begin
            e_rdy[i] = 1'b1;
            if (valid_at[i]) begin
                e_en[i] = 1'b1;
                e_d[i]  = pay[xfers];
                if (flip_pay[xfers]) begin
                    dflip[i + D] = 1'b1;
                    e_bits++;
                end
                xfers++;
            end
            i++;
        end
        for (int t = 0; t < TAIL_LEN; t++) begin
            e_en[i] = 1'b1;
            if (flip_nonpay) dflip[i + D] = 1'b1;
            i++;
        end
        done_idx = i + D;

        // Symbol j of the frame is corrupted when (j mod period) < burst.
        sym = 0;
        for (int c = 0; c < done_idx; c++) begin
            if (e_en[c]) begin
                if (period != 0 && (sym % period) < burst) begin
                    e_mask[c + ENC_LAT] = MASK_BOTH;
                    e_inj += 2;
                end
                sym++;
            end
        end

        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1 drive_idle();
            @(negedge clk);
            idle_checks("gap");
            check_val("gap_bits", 32'(bit_err_ct_o), 32'(last_bits));
            check_val("gap_inj", 32'(inj_ct_o), 32'(last_inj));
        end

        for (int c = 0; c <= done_idx; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                start_i      = 1'b1;
                err_period_i = 8'(period);
                err_burst_i  = 4'(burst);
            end else begin
                start_i      = (c == done_idx) ? start_at_done
                             : (start_busy_rand && $urandom_range(0, 5) == 0);
                err_period_i = 8'($urandom_range(0, 255));
                err_burst_i  = 4'($urandom_range(0, 15));
            end
            din_if.din_valid_i = valid_at[c];
            din_if.din_i       = e_en[c] ? e_d[c] : 1'($urandom_range(0, 1));
            if (c >= D && e_en[c - D]) dec_d_i = e_d[c - D] ^ dflip[c];
            else                       dec_d_i = 1'($urandom_range(0, 1));

            @(negedge clk);
            check_val("ready", 32'(din_if.din_ready_o), 32'(e_rdy[c]));
            check_val("enc_en", 32'(enc_en_o), 32'(e_en[c]));
            if (e_en[c]) check_val("enc_d", 32'(enc_d_o), 32'(e_d[c]));
            check_val("mask", 32'(err_mask_o), 32'(e_mask[c]));
            check_val("busy", 32'(busy_o), 32'(c >= 1 && c < done_idx));
            check_val("done", 32'(done_o), 32'(c == done_idx));
            if (done_o && obs_done < 0) obs_done = c;
            if (c == 0) begin
                check_val("hold_bits", 32'(bit_err_ct_o), 32'(last_bits));
                check_val("hold_inj", 32'(inj_ct_o), 32'(last_inj));
            end
            if (c == 1) begin
                check_val("clr_bits", 32'(bit_err_ct_o), 32'd0);
                check_val("clr_inj", 32'(inj_ct_o), 32'd0);
            end
            if (c == done_idx) begin
                check_val("bit_err_ct", 32'(bit_err_ct_o), 32'(e_bits));
                check_val("inj_ct", 32'(inj_ct_o), 32'(e_inj));
            end
            if (c == abort_at) begin
                $display("frame %0d: period=%0d burst=%0d aborted by reset at cycle %0d",
                         frame_no, period, burst, c);
                frame_no++;
                reset_abort();
                return;
            end
        end
        check_val("done_at", 32'(obs_done), 32'(done_idx));
        $display("frame %0d: period=%0d burst=%0d done@%0d bit_err=%0d inj=%0d",
                 frame_no, period, burst, obs_done, bit_err_ct_o, inj_ct_o);
        frame_no++;
        last_bits = e_bits;
        last_inj  = e_inj;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        din_if.din_valid_i = 1'b0;
        din_if.din_i       = 1'b0;
        start_busy_rand    = 1'b0;
        start_at_done      = 1'b0;
        clear_flips();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_state_busy", 32'(busy_o), 32'd0);
        check_val("rst_state_done", 32'(done_o), 32'd0);
        check_val("rst_state_en", 32'(enc_en_o), 32'd0);
        check_val("rst_state_mask", 32'(err_mask_o), 32'd0);
        check_val("rst_state_bits", 32'(bit_err_ct_o), 32'd0);
        check_val("rst_state_inj", 32'(inj_ct_o), 32'd0);
        rst = 1'b1;

        // No injection, continuous 0xA5 payload, ideal decoder.
        for (int k = 0; k < FRAME_LEN; k++) pay[k] = a5[7 - (k % 8)];
        gen_valid(0);
        run_frame(0, 0, 2, -1);

        // One corrupted symbol every 16.
        rand_pay();
        run_frame(16, 1, 1, -1);

        // Decoder flips payload bit 5; started the cycle after the previous done.
        flip_pay[5] = 1'b1;
        run_frame(0, 0, 0, -1);

        // Decoder flips every tail bit only.
        clear_flips();
        flip_nonpay = 1'b1;
        run_frame(5, 2, 1, -1);

        // Three stall cycles mid-frame.
        clear_flips();
        gen_valid(1);
        run_frame(7, 3, 1, -1);

        // Starts while busy and in the done cycle, then burst >= period.
        start_busy_rand = 1'b1;
        start_at_done   = 1'b1;
        gen_valid(2);
        run_frame(3, 5, 1, -1);
        start_busy_rand = 1'b0;
        start_at_done   = 1'b0;
        run_frame(10, 4, 0, -1);

        // Reset in FLUSH, then a clean frame.
        gen_valid(0);
        run_frame(4, 1, 1, FRAME_LEN + 3);
        rand_pay();
        run_frame(16, 1, 2, -1);

        // Fully random frames.
        for (int r = 0; r < 5; r++) begin
            rand_pay();
            gen_valid(2);
            for (int k = 0; k < FRAME_LEN; k++) flip_pay[k] = ($urandom_range(0, 15) == 0);
            flip_nonpay     = 1'($urandom_range(0, 1));
            start_busy_rand = 1'($urandom_range(0, 1));
            run_frame($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 3), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame-level sequencer for the convolutional encoder → channel → Viterbi decoder link. It accepts payload bits over a valid/ready handshake and drives the encoder enable and data. After each frame it appends zero tail bits to flush the trellis. It generates the channel error-injection mask and checks decoded bits against a delayed copy of the payload, reporting injected and residual error counts per frame.

## Interface
Parameters:
- FRAME_LEN, 64: payload bits per frame (≥1).
- TAIL_LEN, 8: zero flush bits after the payload (≥1).
- ENC_LAT, 1: clocks from enc_en_o/enc_d_o to the encoder output symbol.
- DEC_LAT, 32: clocks from the encoder output symbol to the decoded bit on dec_d_i.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle frame start request; ignored while busy_o=1.
- err_period_i  in  8  injection period in encoder symbols; 0 disables injection; sampled at accepted start.
- err_burst_i  in  4  consecutive corrupted symbols per period; sampled at accepted start.
- din_valid_i  in  1  payload bit valid.
- din_i  in  1  payload bit.
- din_ready_o  out  1  payload accepted when high with din_valid_i.
- enc_en_o  out  1  encoder enable.
- enc_d_o  out  1  encoder data.
- err_mask_o  out  2  XOR mask for the channel, aligned with the encoder output symbol.
- dec_d_i  in  1  decoder output bit.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame end.
- bit_err_ct_o  out  16  payload bits whose decoded value is wrong, current/last frame.
- inj_ct_o  out  16  corrupted channel bits, current/last frame.

## Operation
- FSM states are IDLE, FEED, FLUSH, DRAIN and DONE.
- IDLE:
  - On start_i, latch the config, clear both counters, set busy_o and go to FEED.
- FEED:
  - din_ready_o=1.
  - On a transfer, enc_en_o=1 and enc_d_o=din_i, and the payload counter increments.
  - Stall cycles drive enc_en_o=0.
  - After the FRAME_LEN-th transfer, go to FLUSH.
- FLUSH:
  - din_ready_o=0, enc_en_o=1, enc_d_o=0 for TAIL_LEN cycles, then go to DRAIN.
- DRAIN:
  - enc_en_o=0 for ENC_LAT+DEC_LAT cycles, then go to DONE.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then go to IDLE.
- Injection phase counter:
  - Advances on each enc_en_o cycle (payload and tail).
  - The symbol is corrupted when err_period_i≠0 and phase < err_burst_i. The phase wraps to 0 at err_period_i−1.
  - Phase resets to 0 at frame start.
  - If err_burst_i ≥ err_period_i, every symbol is corrupted.
- Mask output:
  - The mask value (2'b11 when corrupted, else 2'b00) passes through an ENC_LAT-deep delay line to err_mask_o.
  - inj_ct_o adds 2 per corrupted symbol.
- Reference delay line:
  - Depth ENC_LAT+DEC_LAT. It holds {is_payload, bit} and shifts every clock.
  - Payload transfers enter with is_payload=1. Tail bits and idle cycles enter with 0.
  - When the line's tail entry has is_payload=1 and dec_d_i≠bit, bit_err_ct_o increments.
  - The decoder is treated as fixed latency in clocks.
- Counters saturate at 16'hFFFF. They hold their value after done_o until the next accepted start.

## Timing
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Counters, the phase counter and both delay lines cleared.
- Reset mid-frame discards the frame; no done_o is issued.
- The first FEED cycle is the clock after start_i is accepted.
- The encoder output symbol appears ENC_LAT clocks after enc_en_o; err_mask_o has the same alignment.
- The decoded bit for the payload bit transferred at cycle t is compared at cycle t+ENC_LAT+DEC_LAT.
- Minimum frame duration (no stalls): 1 + FRAME_LEN + TAIL_LEN + ENC_LAT + DEC_LAT + 1 clocks from start_i to the done_o cycle.
- A start_i in the same cycle as done_o is ignored. A start_i in the following cycle is accepted.
- A counter increment while at 16'hFFFF leaves the counter at 16'hFFFF.

## Structure
- Package viterbi_pkg holds:
  - the FSM state enum;
  - the localparam for the error-counter width;
  - the mask constants MASK_CLEAN=2'b00 and MASK_BOTH=2'b11.
- One natural sub-module, viterbi_ref_delay: a parameterized-depth shift register used for both the mask delay line and the reference delay line.

## Test plan
- err_period_i=0, continuous payload 0xA5 repeated, ideal decoder model → done_o at 1+64+8+33+1 clocks; bit_err_ct_o=0, inj_ct_o=0.
- err_period_i=16, err_burst_i=1 → err_mask_o=2'b11 on symbols 0, 16, 32, 48 and 64 of 72; inj_ct_o=10.
- Decoder model flips payload bit 5 → bit_err_ct_o=1. A flip during tail or DRAIN cycles → bit_err_ct_o=0.
- din_valid_i low for 3 cycles mid-frame → enc_en_o low on exactly those 3 cycles; done_o delayed by 3; comparison still aligned, count 0.
- start_i while busy and in the DONE cycle → ignored. start_i one cycle after done_o → new frame, counters cleared.
- rst asserted in FLUSH → all outputs 0 immediately; no done_o; the next start runs a clean frame.
